// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receiver for 8-bit frames with a start bit, a parity bit and
// one stop bit. The line is sampled at mid-bit. Each byte is delivered with a
// one-cycle rx_valid strobe, together with parity and framing error flags.
module uart_rx_fsm #(
    parameter int unsigned CLKS_PER_BIT = 1667,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [12:0] HALF_M1 = 13'(CLKS_PER_BIT / 2 - 1);
    localparam logic [12:0] BIT_M1  = 13'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_q;
    logic        sync1_q;
    logic        rx_s_q;
    logic [12:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        par_mis_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        parity_err_q;
    logic        frame_err_q;
    logic        busy_q;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            rx_s_q  <= sync1_q;
        end
    end

    // Receive FSM with bit timing, shift register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_mis_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            cnt_q      <= cnt_q + 13'd1;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            // line went back high before mid-start: glitch
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q     <= '0;
                        par_mis_q <= (^shift_q) ^ rx_s_q ^ PARITY_ODD;
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q        <= '0;
                        rx_data_q    <= shift_q;
                        parity_err_q <= par_mis_q;
                        frame_err_q  <= ~rx_s_q;
                        rx_valid_q   <= 1'b1;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // hold off until the line is released so a break cannot retrigger
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm. One instance uses full 9600-baud timing for a
// single frame and a latency check. A second instance uses a short bit period
// for the remaining scenarios.
module tb_uart_rx_fsm;

    localparam int unsigned CPB  = 64;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned FULL = 1667;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    logic       rx_def;
    logic [7:0] rx_data_def;
    logic       rx_valid_def;
    logic       parity_err_def;
    logic       frame_err_def;
    logic       busy_def;

    int checks;
    int errors;
    int cyc;

    // strobe monitor state, short-bit instance
    int         s_cnt;
    int         s_cyc;
    logic [7:0] s_data;
    logic       s_pe;
    logic       s_fe;
    logic       s_prev;
    logic       s_consec;
    // strobe monitor state, full-rate instance
    int         d_cnt;
    int         d_cyc;
    logic [7:0] d_data;
    logic       d_pe;
    logic       d_fe;

    uart_rx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    uart_rx_fsm #(.CLKS_PER_BIT(FULL), .PARITY_ODD(1'b0)) u_dut_full (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_def),
        .rx_data    (rx_data_def),
        .rx_valid   (rx_valid_def),
        .parity_err (parity_err_def),
        .frame_err  (frame_err_def),
        .busy       (busy_def)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe, sampled just after the active edge
    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            if (s_prev) s_consec = 1'b1;
            s_cnt  = s_cnt + 1;
            s_cyc  = cyc;
            s_data = rx_data;
            s_pe   = parity_err;
            s_fe   = frame_err;
        end
        s_prev = rx_valid;
        if (rx_valid_def) begin
            d_cnt  = d_cnt + 1;
            d_cyc  = cyc;
            d_data = rx_data_def;
            d_pe   = parity_err_def;
            d_fe   = frame_err_def;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit full, input logic v);
        if (full) rx_def = v;
        else rx_in = v;
    endtask

    task automatic hold(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // start, 8 data bits LSB first, parity, stop; line left at the stop value
    task automatic send_frame(input bit full, input logic [7:0] d, input logic p,
                              input logic s, input int unsigned cpb);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int unsigned i = 0; i < 11; i++) begin
            drive(full, bits[i]);
            hold(cpb);
        end
    endtask

    int t0;
    int c1;
    int lat;
    int n0;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        s_cnt = 0; s_cyc = 0; s_data = '0; s_pe = 0; s_fe = 0; s_prev = 0; s_consec = 0;
        d_cnt = 0; d_cyc = 0; d_data = '0; d_pe = 0; d_fe = 0;
        rst = 1'b0; rx_in = 1'b1; rx_def = 1'b1;
        hold(3);
        check("rst_data",  32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_perr",  32'(parity_err), 32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_busy_full", 32'(busy_def), 32'h0);
        rst = 1'b1;
        hold(4);

        // 0x55 at full 9600-baud timing
        t0 = cyc;
        send_frame(1'b1, 8'h55, 1'b0, 1'b1, FULL);
        hold(5);
        lat = d_cyc - t0;
        check("full_cnt",  32'(d_cnt), 32'd1);
        check("full_data", 32'(d_data), 32'h55);
        check("full_perr", 32'(d_pe), 32'h0);
        check("full_ferr", 32'(d_fe), 32'h0);
        check("full_busy", 32'(busy_def), 32'h0);
        check("full_lat_17505pm1", 32'(lat >= 17504 && lat <= 17506), 32'h1);

        // 0xAA then 0xF0 with no idle gap
        t0 = cyc;
        send_frame(1'b0, 8'hAA, 1'b0, 1'b1, CPB);
        c1 = s_cyc;
        lat = c1 - t0;
        check("b2b_lat", 32'(lat >= 673 && lat <= 675), 32'h1);
        check("b2b_cnt1",  32'(s_cnt), 32'd1);
        check("b2b_data1", 32'(s_data), 32'hAA);
        send_frame(1'b0, 8'hF0, 1'b0, 1'b1, CPB);
        check("b2b_cnt2",  32'(s_cnt), 32'd2);
        check("b2b_data2", 32'(s_data), 32'hF0);
        check("b2b_gap",   32'(s_cyc - c1), 32'(11 * CPB));
        check("b2b_perr",  32'(s_pe), 32'h0);
        check("b2b_ferr",  32'(s_fe), 32'h0);
        hold(2 * CPB);
        check("b2b_busy",  32'(busy), 32'h0);

        // wrong parity, then a clean frame clears the flag
        send_frame(1'b0, 8'h0F, 1'b1, 1'b1, CPB);
        check("par_data", 32'(s_data), 32'h0F);
        check("par_perr", 32'(s_pe), 32'h1);
        check("par_ferr", 32'(s_fe), 32'h0);
        hold(CPB);
        check("par_hold", 32'(parity_err), 32'h1);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1, CPB);
        check("par_data2", 32'(s_data), 32'h3C);
        check("par_perr2", 32'(s_pe), 32'h0);
        hold(CPB);

        // stop bit 0 followed by a held-low line
        n0 = s_cnt;
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, CPB);
        check("brk_cnt",  32'(s_cnt), 32'(n0 + 1));
        check("brk_data", 32'(s_data), 32'h81);
        check("brk_ferr", 32'(s_fe), 32'h1);
        check("brk_perr", 32'(s_pe), 32'h0);
        hold(300);
        check("brk_busy_low", 32'(busy), 32'h1);
        rx_in = 1'b1;
        hold(6);
        check("brk_busy_rel", 32'(busy), 32'h0);
        hold(2 * CPB);
        check("brk_no_second", 32'(s_cnt), 32'(n0 + 1));

        // short start glitch is rejected
        n0 = s_cnt;
        rx_in = 1'b0;
        hold(10);
        check("gl_busy_hi", 32'(busy), 32'h1);
        hold(10);
        rx_in = 1'b1;
        hold(2 * CPB);
        check("gl_busy_lo", 32'(busy), 32'h0);
        check("gl_no_strobe", 32'(s_cnt), 32'(n0));
        send_frame(1'b0, 8'h33, 1'b0, 1'b1, CPB);
        check("gl_data", 32'(s_data), 32'h33);
        check("gl_cnt",  32'(s_cnt), 32'(n0 + 1));
        check("gl_perr", 32'(s_pe), 32'h0);
        hold(CPB);

        // low pulse of HALF+2 clocks is a real start bit: line high gives 0xFF, parity 1 wrong
        n0 = s_cnt;
        rx_in = 1'b0;
        hold(HALF + 2);
        rx_in = 1'b1;
        hold(11 * CPB);
        check("min_cnt",  32'(s_cnt), 32'(n0 + 1));
        check("min_data", 32'(s_data), 32'hFF);
        check("min_perr", 32'(s_pe), 32'h1);
        check("min_ferr", 32'(s_fe), 32'h0);
        hold(CPB);

        // reset mid-data aborts the frame
        n0 = s_cnt;
        fork
            send_frame(1'b0, 8'hC3, 1'b0, 1'b1, CPB);
            begin
                hold(4 * CPB + 10);
                rst = 1'b0;
                #1;
                check("mrst_busy", 32'(busy), 32'h0);
                check("mrst_data", 32'(rx_data), 32'h00);
                check("mrst_perr", 32'(parity_err), 32'h0);
                check("mrst_ferr", 32'(frame_err), 32'h0);
            end
        join
        hold(2);
        rst = 1'b1;
        hold(CPB);
        check("mrst_no_strobe", 32'(s_cnt), 32'(n0));
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1, CPB);
        check("mrst_data2", 32'(s_data), 32'hC3);
        check("mrst_cnt",   32'(s_cnt), 32'(n0 + 1));
        check("mrst_perr2", 32'(s_pe), 32'h0);
        check("mrst_ferr2", 32'(s_fe), 32'h0);
        hold(CPB);

        check("no_consec_valid", 32'(s_consec), 32'h0);
        check("full_cnt_end", 32'(d_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

UART receiver: the stage directly downstream of the UART transmitter, deserialising its line output back into bytes. Frame format matches the transmitter: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1). Timing is 9600 baud from a 16 MHz clock (1667 clocks per bit). Each received byte is presented with a one-cycle valid strobe plus parity and framing error flags for the motor-control command decoder.

## Interface
- CLKS_PER_BIT, 1667, clock cycles per bit period; legal range ≥ 16.
- PARITY_ODD, 0, 0 = even parity (data bits + parity bit have an even count of 1s); 1 = odd parity.
- clk  input  1  system clock, 16 MHz; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- rx_in  input  1  serial line, asynchronous to clk; idles high.
- rx_data  output  8  last received byte; changes only with rx_valid.
- rx_valid  output  1  one-cycle strobe: rx_data and error flags updated this cycle.
- parity_err  output  1  parity mismatch on the last frame; updated with rx_valid.
- frame_err  output  1  stop bit sampled 0 on the last frame; updated with rx_valid.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- rx_in passes through a 2-flop synchroniser (rx_s); both flops reset to 1.
- HALF = CLKS_PER_BIT/2, integer division (833 at default).
- Bit counter: 13 bits; clears on every state transition and after every data-bit sample.
- States:
  - IDLE: when rx_s = 0, go to START.
  - START: when count = HALF-1, sample rx_s. If 1, treat as a glitch: return to IDLE with no strobe. If 0, go to DATA.
  - DATA: when count = CLKS_PER_BIT-1, sample rx_s into shift register bit[idx]; idx runs 0..7. After idx 7, go to PARITY.
  - PARITY: when count = CLKS_PER_BIT-1, sample the parity bit and compute the mismatch. Go to STOP.
  - STOP: when count = CLKS_PER_BIT-1, sample the stop bit. In the same cycle, load rx_data, parity_err and frame_err, and pulse rx_valid.
    - Stop bit = 1: go to IDLE.
    - Stop bit = 0: go to BREAK.
  - BREAK: wait for rx_s = 1, then go to IDLE. This prevents a held-low line or break condition from retriggering.
- A frame with errors still strobes rx_valid and updates rx_data. Consumers qualify the data with the error flags.
- Error flags and rx_data hold their values until the next rx_valid.
- rx_valid never asserts on two consecutive cycles.

## Timing
- Reset values:
  - rx_data = 0x00, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - State = IDLE; synchroniser flops = 1.
- Reset asserted mid-frame aborts immediately: no strobe, and all outputs return to their reset values.
- Start detection: a rx_in falling edge is seen in IDLE 2–3 clocks later, because of the synchroniser.
- Sampling is at mid-bit. The data bit k sample occurs at HALF + (k+1)·CLKS_PER_BIT clocks (±3) after the falling edge at the pin.
- rx_valid asserts HALF + 10·CLKS_PER_BIT + 2 clocks after the start-bit falling edge, ±1. This is 17505 ±1 at default, i.e. mid stop bit.
- busy rises 1 clock after the rx_s falling edge and falls the cycle after rx_valid, or on BREAK exit.
- Back-to-back frames: the next start edge arriving ≥ HALF clocks after the stop-bit sample is received correctly. This covers the zero-idle-gap case.
- A start glitch shorter than HALF clocks is rejected. A low pulse held ≥ HALF+2 clocks is accepted as a start bit.

## Test plan
- 0x55 with even parity bit 0 and stop bit 1, at 1667 clk/bit → one rx_valid; rx_data = 0x55; parity_err = 0; frame_err = 0; busy low afterward.
- 0xAA then 0xF0, back-to-back with no idle gap → two strobes, rx_data = 0xAA then 0xF0, no errors, strobes 18337 clocks apart.
- 0x0F sent with parity bit 1 (wrong for even parity) → rx_valid with rx_data = 0x0F and parity_err = 1. A following correct 0x3C clears parity_err to 0.
- 0x81 sent with stop bit 0, line held low for 5000 more clocks, then released high → rx_valid with frame_err = 1. busy stays high until the line returns high, and there is no second strobe.
- rx_in low pulse of 400 clocks → no rx_valid; busy pulses high, then returns to IDLE. A following valid 0x33 is received correctly.
- rst asserted mid-DATA while receiving 0xC3 → outputs reset immediately, no strobe. A subsequent 0xC3 is received correctly.
